// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and widths for the game sequencer
package game_pkg;

  localparam int LIVES_W = 2;
  localparam int TIMER_W = 22;

  typedef enum logic [2:0] {
    ST_SPLASH   = 3'd0,
    ST_READY    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_HIT      = 3'd3,
    ST_GAMEOVER = 3'd4,
    ST_WIN      = 3'd5
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchronizer
// Ports: clk (destination clock), arst_n (async active-low reset, clears to 0),
//        d (asynchronous input), q (synchronized output)
module sync_2ff (
  input  logic clk,
  input  logic arst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - game phase sequencer, lives counter and motion gating
// Ports: btn_clk (1 MHz clock), arst_n (async active-low reset),
//        collision_async (vga-domain overlap level), start_btn (debounced start/skip),
//        player_c/player_r (player top-left position),
//        move_tick (motion strobe in PLAY), enemy_run (enemy motion enable),
//        player_respawn (start-position reload pulse), lives, game_state
module game_flow_ctrl #(
  parameter int SPLASH_TICKS   = 2_000_000,
  parameter int HIT_HOLD_TICKS = 1_000_000,
  parameter int MOVE_DIV       = 10_001,
  parameter int LIVES          = 3,
  parameter int GOAL_C         = 576,
  parameter int GOAL_R         = 416
) (
  input  logic       btn_clk,
  input  logic       arst_n,
  input  logic       collision_async,
  input  logic       start_btn,
  input  logic [9:0] player_c,
  input  logic [8:0] player_r,
  output logic       move_tick,
  output logic       enemy_run,
  output logic       player_respawn,
  output logic [1:0] lives,
  output logic [2:0] game_state
);

  import game_pkg::*;

  localparam int DIV_W = $clog2(MOVE_DIV);

  localparam logic [TIMER_W-1:0] SPLASH_LAST = TIMER_W'(SPLASH_TICKS - 1);
  localparam logic [TIMER_W-1:0] HIT_LAST    = TIMER_W'(HIT_HOLD_TICKS - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(MOVE_DIV - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(LIVES);
  localparam logic [9:0]         GOAL_C_V    = 10'(GOAL_C);
  localparam logic [8:0]         GOAL_R_V    = 9'(GOAL_R);

  state_t               state, state_next;
  logic [TIMER_W-1:0]   timer, timer_next;
  logic [DIV_W-1:0]     div_cnt, div_next;
  logic [LIVES_W-1:0]   lives_next;
  logic                 start_q;
  logic                 press;
  logic                 coll_s;
  logic                 goal;
  logic                 in_play_next;
  logic                 move_tick_next;
  logic                 respawn_next;
  logic                 enemy_run_next;

  sync_2ff u_coll_sync (
    .clk    (btn_clk),
    .arst_n (arst_n),
    .d      (collision_async),
    .q      (coll_s)
  );

  // start_q resets high so a button already held at reset is not a press
  assign press = start_btn & ~start_q;
  assign goal  = (player_c >= GOAL_C_V) && (player_r >= GOAL_R_V);

  always_comb begin
    state_next = state;
    lives_next = lives;
    case (state)
      ST_SPLASH: begin
        if (press || (timer == SPLASH_LAST)) state_next = ST_READY;
      end
      ST_READY: begin
        if (press) state_next = ST_PLAY;
      end
      ST_PLAY: begin
        // collision outranks a simultaneous goal arrival
        if (coll_s) begin
          state_next = ST_HIT;
          if (lives != '0) lives_next = lives - LIVES_W'(1);
        end else if (goal) begin
          state_next = ST_WIN;
        end
      end
      ST_HIT: begin
        if (timer == HIT_LAST) state_next = (lives == '0) ? ST_GAMEOVER : ST_READY;
      end
      ST_GAMEOVER, ST_WIN: begin
        if (press) begin
          state_next = ST_READY;
          lives_next = LIVES_INIT;
        end
      end
      default: state_next = ST_SPLASH;
    endcase

    timer_next = (state_next != state) ? '0 : timer + TIMER_W'(1);

    // divider only runs while staying in PLAY; any exit drops the partial count
    in_play_next   = (state == ST_PLAY) && (state_next == ST_PLAY);
    move_tick_next = in_play_next && (div_cnt == DIV_LAST);
    if (!in_play_next)          div_next = '0;
    else if (div_cnt == DIV_LAST) div_next = '0;
    else                        div_next = div_cnt + DIV_W'(1);

    respawn_next   = (state_next == ST_READY) && (state != ST_READY);
    enemy_run_next = (state_next == ST_PLAY) || (state_next == ST_READY);
  end

  always_ff @(posedge btn_clk or negedge arst_n) begin
    if (!arst_n) begin
      state          <= ST_SPLASH;
      timer          <= '0;
      div_cnt        <= '0;
      lives          <= LIVES_INIT;
      start_q        <= 1'b1;
      move_tick      <= 1'b0;
      player_respawn <= 1'b0;
      enemy_run      <= 1'b0;
    end else begin
      state          <= state_next;
      timer          <= timer_next;
      div_cnt        <= div_next;
      lives          <= lives_next;
      start_q        <= start_btn;
      move_tick      <= move_tick_next;
      player_respawn <= respawn_next;
      enemy_run      <= enemy_run_next;
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed self-checking bench for game_flow_ctrl
module tb_game_flow_ctrl;

  logic       btn_clk;
  logic       arst_n;
  logic       collision_async;
  logic       start_btn;
  logic [9:0] player_c;
  logic [8:0] player_r;
  logic       move_tick;
  logic       enemy_run;
  logic       player_respawn;
  logic [1:0] lives;
  logic [2:0] game_state;

  int tests_run    = 0;
  int tests_failed = 0;

  game_flow_ctrl #(
    .SPLASH_TICKS   (20),
    .HIT_HOLD_TICKS (10),
    .MOVE_DIV       (5),
    .LIVES          (2),
    .GOAL_C         (576),
    .GOAL_R         (416)
  ) dut (
    .btn_clk         (btn_clk),
    .arst_n          (arst_n),
    .collision_async (collision_async),
    .start_btn       (start_btn),
    .player_c        (player_c),
    .player_r        (player_r),
    .move_tick       (move_tick),
    .enemy_run       (enemy_run),
    .player_respawn  (player_respawn),
    .lives           (lives),
    .game_state      (game_state)
  );

  initial btn_clk = 1'b0;
  always #5 btn_clk = ~btn_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge btn_clk);
      #1;
    end
  endtask

  // release, then press; the press is taken on the second edge
  task automatic press_btn();
    start_btn = 1'b0;
    tick(1);
    start_btn = 1'b1;
    tick(1);
    start_btn = 1'b0;
  endtask

  task automatic pulse_collision();
    collision_async = 1'b1;
    tick(1);
    collision_async = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n          = 1'b0;
    start_btn       = 1'b0;
    collision_async = 1'b0;
    player_c        = '0;
    player_r        = '0;
    tick(2);

    // reset values
    check("rst_state",   game_state,     0);
    check("rst_lives",   lives,          2);
    check("rst_tick",    move_tick,      0);
    check("rst_respawn", player_respawn, 0);
    check("rst_enemy",   enemy_run,      0);

    // 1: splash timeout
    arst_n = 1'b1;
    tick(19);
    check("splash_hold",   game_state,     0);
    check("splash_enemy0", enemy_run,      0);
    tick(1);
    check("splash_to_rdy", game_state,     1);
    check("rdy_respawn",   player_respawn, 1);
    check("rdy_enemy",     enemy_run,      1);
    tick(1);
    check("respawn_once",  player_respawn, 0);
    check("rdy_stay",      game_state,     1);

    // 2: button held through reset does not skip splash
    start_btn = 1'b1;
    arst_n    = 1'b0;
    tick(2);
    arst_n = 1'b1;
    tick(19);
    check("held_no_skip", game_state, 0);
    tick(1);
    check("held_timeout", game_state, 1);
    press_btn();
    check("press_play", game_state, 2);
    check("play_enemy", enemy_run,  1);
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      check($sformatf("move_tick_%0d", i), move_tick, (i % 5 == 0) ? 1 : 0);
    end

    // 3: two collisions end the game
    pulse_collision();
    tick(1);
    check("coll_lat_2", game_state, 2);
    tick(1);
    check("coll_hit",   game_state, 3);
    check("coll_lives", lives,      1);
    check("hit_enemy",  enemy_run,  0);
    tick(9);
    check("hit_hold",   game_state, 3);
    tick(1);
    check("hit_to_rdy", game_state, 1);
    check("hit_respawn", player_respawn, 1);
    press_btn();
    check("replay", game_state, 2);
    pulse_collision();
    tick(2);
    check("coll2_hit",   game_state, 3);
    check("coll2_lives", lives,      0);
    tick(10);
    check("gameover",    game_state, 4);
    check("go_lives",    lives,      0);
    check("go_enemy",    enemy_run,  0);
    check("go_tick",     move_tick,  0);
    tick(3);
    check("go_stay",     game_state, 4);
    check("go_tick2",    move_tick,  0);

    // 5a: restart from game over
    press_btn();
    check("restart_state",   game_state,     1);
    check("restart_lives",   lives,          2);
    check("restart_respawn", player_respawn, 1);

    // 4: win, then win vs collision in the same cycle
    press_btn();
    check("win_pre_play", game_state, 2);
    player_c = 10'd600;
    player_r = 9'd420;
    tick(1);
    check("win_state", game_state, 5);
    check("win_enemy", enemy_run,  0);
    check("win_lives", lives,      2);
    player_c = '0;
    player_r = '0;
    press_btn();
    check("win_restart", game_state, 1);
    press_btn();
    check("sim_play", game_state, 2);
    pulse_collision();
    tick(1);
    player_c = 10'd600;
    player_r = 9'd420;
    tick(1);
    check("sim_hit",   game_state, 3);
    check("sim_lives", lives,      1);
    player_c = '0;
    player_r = '0;
    tick(10);
    check("sim_to_rdy", game_state, 1);

    // 5b: asynchronous reset mid-play with divider at 3
    press_btn();
    check("mid_play", game_state, 2);
    tick(3);
    check("mid_tick0", move_tick, 0);
    arst_n = 1'b0;
    #1;
    check("arst_state",   game_state,     0);
    check("arst_lives",   lives,          2);
    check("arst_enemy",   enemy_run,      0);
    check("arst_respawn", player_respawn, 0);
    check("arst_tick",    move_tick,      0);
    tick(1);
    arst_n = 1'b1;
    tick(1);
    check("post_rst_state", game_state, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer for the VGA maze game. It runs in the `btn_clk` (1 MHz) domain and steps the game through splash, ready, play, hit, game-over and win phases. It gates player and enemy motion, counts lives and requests a player respawn. It also converts the pixel-domain collision level into a clean, synchronized game event.

## Interface
Parameters:
- `SPLASH_TICKS`, 2_000_000: `btn_clk` cycles spent in SPLASH; must be ≤ 2^22.
- `HIT_HOLD_TICKS`, 1_000_000: `btn_clk` cycles spent in HIT (freeze after collision).
- `MOVE_DIV`, 10_001: period of `move_tick` in cycles; must be ≥ 2.
- `LIVES`, 3: lives loaded at reset and restart; range 1..3.
- `GOAL_C`, 576: player column threshold for a win.
- `GOAL_R`, 416: player row threshold for a win.

Ports:
- `btn_clk` in 1: clock, 1 MHz.
- `arst_n` in 1: reset, asynchronous, active-low.
- `collision_async` in 1: level from `vga_clk` domain; high while player overlaps an enemy.
- `start_btn` in 1: start/skip button, active-high, already debounced.
- `player_c` in 10: player top-left column.
- `player_r` in 9: player top-left row.
- `move_tick` out 1: one-cycle motion strobe, issued only in PLAY.
- `enemy_run` out 1: high while enemies may move.
- `player_respawn` out 1: one-cycle pulse; the position logic reloads the start position.
- `lives` out 2: remaining lives.
- `game_state` out 3: current state encoding.

## Operation
- **State encoding:** SPLASH=0, READY=1, PLAY=2, HIT=3, GAMEOVER=4, WIN=5. Codes 6/7 are illegal and go to SPLASH on the next cycle.
- **Start press detection:** `press = start_btn & ~start_q`. `start_q` resets to 1, so a button held through reset does not count as a press.
- **Collision synchronization:** `collision_async` passes through 2 flip-flops to give `coll_s`.
- **Timer:** a 22-bit `timer` clears on every state change and counts up otherwise.
- **SPLASH:**
  - Go to READY when `timer == SPLASH_TICKS-1` or on `press`, whichever comes first.
- **READY:**
  - `player_respawn` pulses on the first cycle of READY.
  - Go to PLAY on `press`.
- **PLAY:**
  - Priority 1: `coll_s` → HIT, and `lives` decrements by 1 on that transition.
  - Priority 2: `player_c >= GOAL_C && player_r >= GOAL_R` → WIN.
  - A collision in the same cycle as a win condition takes priority.
- **HIT:**
  - On `timer == HIT_HOLD_TICKS-1`: if `lives == 0` go to GAMEOVER, else go to READY.
  - `coll_s` is ignored in this state.
- **GAMEOVER / WIN:**
  - On `press`: reload `lives = LIVES` and go to READY.
- **Motion divider:**
  - The divider counter is 0 outside PLAY.
  - In PLAY it counts 0..MOVE_DIV-1 and wraps.
  - `move_tick` = 1 when count == MOVE_DIV-1.
- **Enemy gating:** `enemy_run = (state == PLAY) || (state == READY)`. Enemies patrol while the player waits and freeze in HIT, GAMEOVER and WIN.
- **Lives:** `lives` never underflows; a decrement is only possible from a nonzero value.

## Timing
- **Reset values:**
  - State = SPLASH, `lives = LIVES`, timer = 0, divider = 0.
  - `move_tick = 0`, `player_respawn = 0`, `enemy_run = 0`, `game_state = 0`.
- **Output registering:** all outputs are registered. `game_state` follows a transition 1 cycle after the deciding edge.
- **Collision latency:** a collision rising edge reaches a HIT transition 3 cycles later (2 sync stages + 1 state register).
- **Press latency:** a press is acted on at the edge after `start_btn` rises and appears on `game_state` 1 cycle later.
- **Respawn pulse:** `player_respawn` is high in the same cycle that `game_state` first reads READY, for exactly 1 cycle.
- **First motion strobe:** the first `move_tick` after entering PLAY comes MOVE_DIV cycles later.
- **Leaving PLAY:** a pending divider count is discarded on exit from PLAY.
- **Reset mid-operation:** asynchronous reset returns all registers to their reset values immediately, regardless of state.

## Structure
- **Package `game_pkg`:**
  - State encoding constants (SPLASH..WIN).
  - `LIVES_W = 2`.
  - `TIMER_W = 22`.
- **Sub-module `sync_2ff`:** a single-bit 2-flop synchronizer with async active-low reset to 0, used for `collision_async`.
- The FSM, timer, divider and lives logic stay flat in `game_flow_ctrl`.

## Test plan
Bench parameters: SPLASH_TICKS=20, HIT_HOLD_TICKS=10, MOVE_DIV=5, LIVES=2.
1. **Splash timeout and ready:** release reset and apply no input → `game_state` is 0 for 20 cycles then becomes 1; `player_respawn` pulses once; `enemy_run = 1`.
2. **Held button:** hold `start_btn = 1` through reset → no skip; state reaches READY only by timeout. Then release and press → PLAY; `move_tick` fires every 5th cycle, the first one 5 cycles after entry.
3. **Game over:** in PLAY, pulse `collision_async` → HIT 3 cycles later and `lives` 2→1. After 10 cycles → READY with respawn. Repeat the collision → `lives = 0`, then GAMEOVER after the hold; `move_tick` and `enemy_run` stay 0.
4. **Win and simultaneous events:** set `player_c=600`, `player_r=420` in PLAY → WIN. Repeat with `coll_s` rising in the same cycle → HIT wins the priority and `lives` decrements.
5. **Restart and reset mid-play:** press in GAMEOVER → `lives = 2`, READY. Assert `arst_n = 0` mid-PLAY with the divider at 3 → all outputs return to reset values immediately.
